// File: rtl/adc_ctrl_pio.sv
// Avalon-MM PIO for ADC enables with an auto-off countdown timer.
// Define ADC_CTRL_PIO_IRQ_EN to enable the IE bit and the irq output.
module adc_ctrl_pio #(
  parameter int              WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int              CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam logic [2:0] A_DATA = 3'd0;
  localparam logic [2:0] A_SET  = 3'd1;
  localparam logic [2:0] A_CLR  = 3'd2;
  localparam logic [2:0] A_MASK = 3'd3;
  localparam logic [2:0] A_TMR  = 3'd4;
  localparam logic [2:0] A_STAT = 3'd5;

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             exp_q, exp_d;
  logic             ie_q, ie_d;

  logic             wr;
  logic             wr_data, wr_set, wr_clr;
  logic             wr_mask, wr_tmr, wr_stat;
  logic             busy, fire;
  logic [WIDTH-1:0] wd_w;
  logic [CNT_W-1:0] wd_c;
  logic             unused_wd;

  assign wr      = chipselect & ~write_n;
  assign wr_data = wr & (address == A_DATA);
  assign wr_set  = wr & (address == A_SET);
  assign wr_clr  = wr & (address == A_CLR);
  assign wr_mask = wr & (address == A_MASK);
  assign wr_tmr  = wr & (address == A_TMR);
  assign wr_stat = wr & (address == A_STAT);

  assign wd_w      = writedata[WIDTH-1:0];
  assign wd_c      = writedata[CNT_W-1:0];
  assign unused_wd = ^writedata;

  assign busy = |cnt_q;
  // A timer reload on the final count edge pre-empts the expiry.
  assign fire = (cnt_q == CNT_W'(1)) & ~wr_tmr;

  always_comb begin
    data_d = data_q;
    if (fire) data_d = data_q & ~mask_q;
    unique case (1'b1)
      wr_data: data_d = wd_w;
      wr_set:  data_d = data_d | wd_w;
      wr_clr:  data_d = data_d & ~wd_w;
      default: ;
    endcase
  end

  always_comb begin
    mask_d = wr_mask ? wd_w : mask_q;
    cnt_d  = cnt_q;
    if (wr_tmr)    cnt_d = wd_c;
    else if (busy) cnt_d = cnt_q - CNT_W'(1);
    exp_d = (exp_q & ~(wr_stat & writedata[1])) | fire;
  end

`ifdef ADC_CTRL_PIO_IRQ_EN
  assign ie_d = wr_stat ? writedata[2] : ie_q;
  assign irq  = exp_q & ie_q;
`else
  assign ie_d = 1'b0;
  assign irq  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= RESET_VALUE;
      mask_q <= '0;
      cnt_q  <= '0;
      exp_q  <= 1'b0;
      ie_q   <= 1'b0;
    end else begin
      data_q <= data_d;
      mask_q <= mask_d;
      cnt_q  <= cnt_d;
      exp_q  <= exp_d;
      ie_q   <= ie_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      A_DATA:  readdata = 32'(data_q);
      A_MASK:  readdata = 32'(mask_q);
      A_TMR:   readdata = 32'(cnt_q);
      A_STAT:  readdata[2:0] = {ie_q, exp_q, busy};
      default: readdata = '0;
    endcase
  end

  assign out_port = data_q;

endmodule
